hall_speed_decoder: RTL and testbench
=====================================

Name: hall_speed_decoder

Overview:
Feedback side of the motor commutation interface. Samples the same 3-bit hall lines the phase driver commutates from, and produces the following for higher-level motion control:
- debounced hall state
- signed step position
- rotation direction
- inter-edge period measurement
- invalid-code, skipped-state and stall flags

One instance sits beside each motor driver in the FPGA motor subsystem.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the hall inputs before any logic (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive identical synced samples required to accept a new hall code (minimum 1)
PERIOD_WIDTH, 20, width of the period counter and the period output
POS_WIDTH, 16, width of the signed position counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
hall  input  3  raw hall sensor lines, asynchronous to clk
clr  input  1  synchronous clear of position, active-high
hall_state  output  3  last accepted debounced hall code
position  output  POS_WIDTH  signed step count, two's complement
dir  output  1  1 = forward, 0 = reverse (direction of the last valid step)
period  output  PERIOD_WIDTH  clk cycles between the last two same-direction accepted steps
period_valid  output  1  period holds a valid measurement
step  output  1  one-cycle pulse per accepted valid step
stalled  output  1  no accepted step for 2^PERIOD_WIDTH-1 cycles
hall_err  output  1  one-cycle pulse when code 3'b000 or 3'b111 is accepted
seq_err  output  1  one-cycle pulse when a valid-to-valid transition skips states

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0; position = 0.
- Sync chain, debounce candidate and counter cleared.
- Accepted code = 3'b000; FSM = INIT.

Synchronizer and debounce:
- Synced value h_s is SYNC_STAGES flops after the pin.
- If h_s != cand: cand <= h_s, cnt <= 0.
- Otherwise cnt increments, saturating at DEBOUNCE_CYCLES-1.
- When cnt == DEBOUNCE_CYCLES-1 and cand != hall_state, cand is accepted.
- Latency from a pin change to the step/error pulse and updated outputs is exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks (19 at defaults).
- A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.

Sequence:
- Valid codes map to indices 1→0, 3→1, 2→2, 6→3, 4→4, 5→5.
- Forward means idx_new = (idx_old+1) mod 6; reverse means idx_new = (idx_old+5) mod 6.

Period counter:
- Increments every cycle and saturates at all-ones.
- Reset to 1 on every accepted code change.

FSM states: INIT, TRACK, STALL.
- INIT: entered on reset or after any invalid code.
  - First accepted valid code sets hall_state → TRACK; no step, no position change, period_valid = 0.
  - An accepted invalid code updates hall_state, pulses hall_err, and stays in INIT.
- TRACK, on an accepted code:
  - Forward: position+1, dir = 1, step pulse.
  - Reverse: position-1, dir = 0, step pulse.
  - Either step: if its direction equals dir and a previous step exists since entering TRACK, period <= counter and period_valid = 1. Otherwise period_valid = 0 (first step, or a reversal).
  - Skip (idx difference 2 or 3): seq_err pulse; position and dir unchanged; period_valid = 0; stays in TRACK.
  - Invalid code (000/111): hall_err pulse, period_valid = 0 → INIT.
- TRACK, period counter reaches all-ones: stalled = 1, period_valid = 0 → STALL.
- STALL: next accepted valid step is processed as in TRACK, except period_valid stays 0. stalled clears on that step → TRACK. An invalid code → INIT with stalled cleared.

Position and clear:
- Position wraps modulo 2^POS_WIDTH without a flag.
- clr forces position to 0 the same cycle. If clr coincides with a step, clr wins (position = 0) but step, dir and period still update.

Reset mid-operation: everything returns to reset values immediately. No pulse may be emitted in the cycle rst_n deasserts.

Test Plan:
- Forward rotation: hall 1,3,2,6,4,5,1 with each code held 1000 cycles after reset → 6 step pulses; position = 6; dir = 1. Each pulse lands 19 cycles after its pin change. period_valid = 1 from the second step on, with period = 1000.
- Reverse rotation: from code 1, apply 5,4,6 at 500-cycle spacing → position = -3; dir = 0. Period = 500, valid from the second step. A reversal step drops period_valid for exactly that step.
- Glitch and skip: 10-cycle pulse from code 3 to 2 → no change. Code 3 then 6 held (skip) → seq_err pulse; position unchanged; period_valid = 0.
- Invalid codes: hold 3'b111 → hall_err pulse, FSM INIT, hall_state = 7. Then code 5 → no step. Then code 1 → step; position +1.
- Stall: PERIOD_WIDTH = 8, hold code 3 for 300 cycles → stalled = 1 at counter 255; period_valid = 0. Next forward code → stalled = 0, step, period_valid still 0.
- Clear and reset: assert clr in the exact cycle of a step → position = 0, dir updated. Drop rst_n mid-rotation → all outputs 0 asynchronously.

Source files
------------

// File: rtl/hall_speed_decoder.sv
// Hall-sensor feedback decoder: synchronizes and debounces the 3-bit hall
// lines, then tracks step position, direction, edge-to-edge period, and
// reports invalid codes, skipped states and stalls.
module hall_speed_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_WIDTH    = 20,
  parameter int POS_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  hall,
  input  logic                        clr,
  output logic [2:0]                  hall_state,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic [PERIOD_WIDTH-1:0]     period,
  output logic                        period_valid,
  output logic                        step,
  output logic                        stalled,
  output logic                        hall_err,
  output logic                        seq_err
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
  localparam logic [POS_WIDTH-1:0]    POS_ONE = POS_WIDTH'(1);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_STALL} state_e;

  // Position of a valid hall code in the six-step forward sequence.
  function automatic logic [2:0] code_idx(input logic [2:0] c);
    case (c)
      3'd1:    code_idx = 3'd0;
      3'd3:    code_idx = 3'd1;
      3'd2:    code_idx = 3'd2;
      3'd6:    code_idx = 3'd3;
      3'd4:    code_idx = 3'd4;
      3'd5:    code_idx = 3'd5;
      default: code_idx = 3'd0;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  h_s;
  logic [2:0]                  cand_q;
  logic [CNT_W-1:0]            cnt_q;

  state_e                  state_q, state_d;
  logic [2:0]              hall_state_q, hall_state_d;
  logic [POS_WIDTH-1:0]    pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic                    pv_q, pv_d;
  logic                    stalled_q, stalled_d;
  logic                    have_prev_q, have_prev_d;
  logic                    step_q, step_d;
  logic                    hall_err_q, hall_err_d;
  logic                    seq_err_q, seq_err_d;

  logic       accept, cand_valid, is_fwd, is_rev;
  logic [3:0] idx_sum, idx_diff;

  assign h_s = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer on the asynchronous hall pins.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], hall};
  end

  // Debounce: restart the stability count whenever the synced code moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (h_s != cand_q) begin
      cand_q <= h_s;
      cnt_q  <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q  <= cnt_q + CNT_ONE;
    end
  end

  assign accept     = (cnt_q == CNT_MAX) && (cand_q != hall_state_q);
  assign cand_valid = (cand_q != 3'b000) && (cand_q != 3'b111);
  assign idx_sum    = {1'b0, code_idx(cand_q)} + 4'd6 - {1'b0, code_idx(hall_state_q)};
  assign idx_diff   = (idx_sum >= 4'd6) ? (idx_sum - 4'd6) : idx_sum;
  assign is_fwd     = cand_valid && (idx_diff == 4'd1);
  assign is_rev     = cand_valid && (idx_diff == 4'd5);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_INIT:  if (accept && cand_valid) state_d = S_TRACK;
      S_TRACK: begin
        if (accept) begin
          if (!cand_valid) state_d = S_INIT;
        end else if (per_cnt_q == PER_MAX) begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (accept) begin
          if (!cand_valid)           state_d = S_INIT;
          else if (is_fwd || is_rev) state_d = S_TRACK;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Output / datapath next values for each state.
  always_comb begin
    hall_state_d = hall_state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    period_d     = period_q;
    pv_d         = pv_q;
    stalled_d    = stalled_q;
    have_prev_d  = have_prev_q;
    step_d       = 1'b0;
    hall_err_d   = 1'b0;
    seq_err_d    = 1'b0;

    if (accept) hall_state_d = cand_q;

    case (state_q)
      S_INIT: begin
        stalled_d = 1'b0;
        if (accept) begin
          pv_d        = 1'b0;
          have_prev_d = 1'b0;
          hall_err_d  = !cand_valid;
        end
      end
      S_TRACK, S_STALL: begin
        if (accept) begin
          if (!cand_valid) begin
            hall_err_d = 1'b1;
            pv_d       = 1'b0;
            stalled_d  = 1'b0;
          end else if (is_fwd || is_rev) begin
            step_d      = 1'b1;
            dir_d       = is_fwd;
            pos_d       = is_fwd ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
            stalled_d   = 1'b0;
            have_prev_d = 1'b1;
            // A period is meaningful only between two same-direction steps
            // with no stall in between.
            if (state_q == S_TRACK && have_prev_q && (is_fwd == dir_q)) begin
              period_d = per_cnt_q;
              pv_d     = 1'b1;
            end else begin
              pv_d     = 1'b0;
            end
          end else begin
            seq_err_d = 1'b1;
            pv_d      = 1'b0;
          end
        end else if (state_q == S_TRACK && per_cnt_q == PER_MAX) begin
          stalled_d = 1'b1;
          pv_d      = 1'b0;
        end
      end
      default: ;
    endcase

    if (clr) pos_d = '0;
  end

  // Free-running saturating period counter, restarted on each accepted code.
  always_comb begin
    if (accept)                    per_cnt_d = PER_ONE;
    else if (per_cnt_q != PER_MAX) per_cnt_d = per_cnt_q + PER_ONE;
    else                           per_cnt_d = per_cnt_q;
  end

  // Registered outputs and tracking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_state_q <= 3'b000;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      period_q     <= '0;
      per_cnt_q    <= '0;
      pv_q         <= 1'b0;
      stalled_q    <= 1'b0;
      have_prev_q  <= 1'b0;
      step_q       <= 1'b0;
      hall_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      hall_state_q <= hall_state_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      period_q     <= period_d;
      per_cnt_q    <= per_cnt_d;
      pv_q         <= pv_d;
      stalled_q    <= stalled_d;
      have_prev_q  <= have_prev_d;
      step_q       <= step_d;
      hall_err_q   <= hall_err_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign hall_state   = hall_state_q;
  assign position     = pos_q;
  assign dir          = dir_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign step         = step_q;
  assign stalled      = stalled_q;
  assign hall_err     = hall_err_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_hall_speed_decoder.sv
// Self-checking bench for hall_speed_decoder. Each applied hall code pushes
// the expected pulse and output snapshot into a queue; a monitor pops and
// compares whenever the decoder emits step / hall_err / seq_err.
module tb_hall_speed_decoder;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_STEP = 3'b100;
  localparam logic [2:0] K_HERR = 3'b010;
  localparam logic [2:0] K_SEQ  = 3'b001;
  localparam int         LATENCY = 19;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  hs;
    logic [15:0] pos;
    logic        dir;
    logic        pv;
    logic [19:0] per;
    int          t0;
  } exp_t;

  logic clk, rst_n, clr;
  logic [2:0] hall;

  logic [2:0]  hall_state;
  logic [15:0] position;
  logic        dir, period_valid, step, stalled, hall_err, seq_err;
  logic [19:0] period;

  logic [2:0]  s_hall_state;
  logic [15:0] s_position;
  logic        s_dir, s_period_valid, s_step, s_stalled, s_hall_err, s_seq_err;
  logic [7:0]  s_period;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  hall_speed_decoder dut (
    .clk(clk), .rst_n(rst_n), .hall(hall), .clr(clr),
    .hall_state(hall_state), .position(position), .dir(dir),
    .period(period), .period_valid(period_valid), .step(step),
    .stalled(stalled), .hall_err(hall_err), .seq_err(seq_err)
  );

  // Narrow period counter so a stall is reachable in a short run.
  hall_speed_decoder #(.PERIOD_WIDTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .hall(hall), .clr(clr),
    .hall_state(s_hall_state), .position(s_position), .dir(s_dir),
    .period(s_period), .period_valid(s_period_valid), .step(s_step),
    .stalled(s_stalled), .hall_err(s_hall_err), .seq_err(s_seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive a hall code at the current negedge, queue its expected effect,
  // then hold it; optionally raise clr for exactly the step cycle.
  task automatic apply(input logic [2:0] code, input int hold, input logic [2:0] kind,
                       input logic [15:0] pos, input logic d, input logic pv,
                       input logic [19:0] per, input bit clr_at_step);
    exp_t e;
    hall = code;
    if (kind != K_NONE) begin
      e.kind = kind; e.hs = code; e.pos = pos; e.dir = d;
      e.pv = pv; e.per = per; e.t0 = cyc;
      sb_q.push_back(e);
    end
    if (clr_at_step) begin
      repeat (LATENCY - 1) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (hold - LATENCY) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
    end
    check("hall_state_after_hold", {29'd0, hall_state}, {29'd0, code});
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (step || hall_err || seq_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, step, hall_err, seq_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind",  {29'd0, step, hall_err, seq_err}, {29'd0, e.kind});
        check("latency",     cyc - e.t0, LATENCY);
        check("hall_state",  {29'd0, hall_state}, {29'd0, e.hs});
        check("position",    {16'd0, position}, {16'd0, e.pos});
        check("dir",         {31'd0, dir}, {31'd0, e.dir});
        check("period_valid", {31'd0, period_valid}, {31'd0, e.pv});
        if (e.pv) check("period", {12'd0, period}, {12'd0, e.per});
        check("stalled_at_pulse", {31'd0, stalled}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hall = 3'd0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hall_state", {29'd0, hall_state}, 32'd0);
    check("rst_position",   {16'd0, position}, 32'd0);
    check("rst_dir",        {31'd0, dir}, 32'd0);
    check("rst_period",     {12'd0, period}, 32'd0);
    check("rst_pv",         {31'd0, period_valid}, 32'd0);
    check("rst_pulses",     {29'd0, step, hall_err, seq_err}, 32'd0);
    check("rst_stalled",    {31'd0, stalled}, 32'd0);
    rst_n = 1'b1;

    // Forward rotation, 1000-cycle spacing.
    apply(3'd1, 1000, K_NONE, 16'd0, 1'b0, 1'b0, 20'd0, 1'b0);
    check("init_no_move", {16'd0, position}, 32'd0);
    apply(3'd3, 1000, K_STEP, 16'd1, 1'b1, 1'b0, 20'd0,    1'b0);
    apply(3'd2, 1000, K_STEP, 16'd2, 1'b1, 1'b1, 20'd1000, 1'b0);
    apply(3'd6, 1000, K_STEP, 16'd3, 1'b1, 1'b1, 20'd1000, 1'b0);
    apply(3'd4, 1000, K_STEP, 16'd4, 1'b1, 1'b1, 20'd1000, 1'b0);
    apply(3'd5, 1000, K_STEP, 16'd5, 1'b1, 1'b1, 20'd1000, 1'b0);
    apply(3'd1, 1000, K_STEP, 16'd6, 1'b1, 1'b1, 20'd1000, 1'b0);

    // Reverse, then reverse back to forward; each reversal drops period_valid once.
    apply(3'd5, 500, K_STEP, 16'd5, 1'b0, 1'b0, 20'd0,   1'b0);
    apply(3'd4, 500, K_STEP, 16'd4, 1'b0, 1'b1, 20'd500, 1'b0);
    apply(3'd6, 500, K_STEP, 16'd3, 1'b0, 1'b1, 20'd500, 1'b0);
    apply(3'd4, 500, K_STEP, 16'd4, 1'b1, 1'b0, 20'd0,   1'b0);
    apply(3'd5, 500, K_STEP, 16'd5, 1'b1, 1'b1, 20'd500, 1'b0);
    apply(3'd1, 500, K_STEP, 16'd6, 1'b1, 1'b1, 20'd500, 1'b0);
    apply(3'd3, 500, K_STEP, 16'd7, 1'b1, 1'b1, 20'd500, 1'b0);

    // 10-cycle glitch 3->2 is ignored.
    hall = 3'd2;
    repeat (10) @(negedge clk);
    hall = 3'd3;
    repeat (100) @(negedge clk);
    check("glitch10_hs",  {29'd0, hall_state}, 32'd3);
    check("glitch10_pos", {16'd0, position}, 32'd7);

    // Skip 3 -> 6.
    apply(3'd6, 500, K_SEQ, 16'd7, 1'b1, 1'b0, 20'd0, 1'b0);

    // Longest rejected glitch: DEBOUNCE_CYCLES-1 cycles.
    hall = 3'd4;
    repeat (15) @(negedge clk);
    hall = 3'd6;
    repeat (100) @(negedge clk);
    check("glitch15_hs",  {29'd0, hall_state}, 32'd6);
    check("glitch15_pos", {16'd0, position}, 32'd7);

    // Invalid code, re-entry without step, then a counted step.
    apply(3'd7, 500, K_HERR, 16'd7, 1'b1, 1'b0, 20'd0, 1'b0);
    apply(3'd5, 500, K_NONE, 16'd0, 1'b0, 1'b0, 20'd0, 1'b0);
    check("reinit_no_move", {16'd0, position}, 32'd7);
    apply(3'd1, 500, K_STEP, 16'd8, 1'b1, 1'b0, 20'd0, 1'b0);

    // clr coincident with a step wins on position only.
    apply(3'd3, 500, K_STEP, 16'd0,     1'b1, 1'b1, 20'd500, 1'b1);
    apply(3'd2, 500, K_STEP, 16'd1,     1'b1, 1'b1, 20'd500, 1'b0);
    apply(3'd3, 500, K_STEP, 16'd0,     1'b0, 1'b0, 20'd0,   1'b0);
    apply(3'd1, 500, K_STEP, 16'hFFFF,  1'b0, 1'b1, 20'd500, 1'b0);
    check("sb_empty_mid", sb_q.size(), 32'd0);

    // Asynchronous reset mid-rotation, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hs",  {29'd0, hall_state}, 32'd0);
    check("async_rst_pos", {16'd0, position}, 32'd0);
    check("async_rst_per", {12'd0, period}, 32'd0);
    check("async_rst_pv",  {31'd0, period_valid}, 32'd0);
    hall = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stall on the narrow-counter instance.
    apply(3'd1, 100, K_NONE, 16'd0, 1'b0, 1'b0, 20'd0, 1'b0);
    apply(3'd3, 300, K_STEP, 16'd1, 1'b1, 1'b0, 20'd0, 1'b0);
    check("s_stalled_set",   {31'd0, s_stalled}, 32'd1);
    check("s_pv_in_stall",   {31'd0, s_period_valid}, 32'd0);
    check("main_not_stalled", {31'd0, stalled}, 32'd0);
    apply(3'd2, 100, K_STEP, 16'd2, 1'b1, 1'b1, 20'd300, 1'b0);
    check("s_stalled_clr",   {31'd0, s_stalled}, 32'd0);
    check("s_pv_after_stall", {31'd0, s_period_valid}, 32'd0);
    check("s_pos_after_stall", {16'd0, s_position}, 32'd2);
    check("s_dir_after_stall", {31'd0, s_dir}, 32'd1);
    check("sb_empty_end", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
